// File: rtl/gte_mac_accum.sv
// gte_mac_accum: pipelined signed multiply-accumulate with a 44-bit wrapping accumulator,
// sticky overflow flags and an optional >>>12 on the 32-bit result.
module gte_mac_accum #(
  parameter int MULW = 16,
  parameter int ACCW = 44,
  parameter int OUTW = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_first,
  input  logic                   i_last,
  input  logic                   i_sf,
  input  logic signed [MULW-1:0] i_a,
  input  logic signed [MULW-1:0] i_b,
  input  logic signed [31:0]     i_bias,
  output logic                   o_valid,
  output logic [OUTW-1:0]        o_mac,
  output logic                   o_ovf_pos,
  output logic                   o_ovf_neg,
  output logic                   o_busy
);
  typedef enum logic {IDLE, OPEN} seqState_t;
  localparam int SUMW = ACCW + 2;
  localparam logic signed [SUMW-1:0] accMax = SUMW'((64'sd1 <<< (ACCW - 1)) - 64'sd1);
  localparam logic signed [SUMW-1:0] accMin = ~accMax;
  seqState_t state, stateNext;
  logic accept, pValid, pFirst, pLast, pSf, stickyPos, stickyNeg, flagPos, flagNeg;
  logic signed [2*MULW-1:0] pProd;
  logic signed [31:0] pBias;
  logic [ACCW-1:0] acc;
  logic signed [SUMW-1:0] base, sum;
  logic [OUTW-1:0] macNext;

  always_comb begin
    accept = i_valid && (i_first || state == OPEN);
    stateNext = accept ? (i_last ? IDLE : OPEN) : state;
    base = pFirst ? SUMW'(pBias) <<< 12 : SUMW'(signed'(acc));
    sum = base + SUMW'(pProd);
    flagPos = (!pFirst && stickyPos) || sum > accMax;
    flagNeg = (!pFirst && stickyNeg) || sum < accMin;
    macNext = OUTW'(signed'(sum[ACCW-1:0]) >>> (pSf ? 12 : 0));
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= stateNext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pValid <= 1'b0;
      pFirst <= 1'b0;
      pLast <= 1'b0;
      pSf <= 1'b0;
      pProd <= '0;
      pBias <= '0;
      acc <= '0;
      stickyPos <= 1'b0;
      stickyNeg <= 1'b0;
      o_valid <= 1'b0;
      o_mac <= '0;
      o_ovf_pos <= 1'b0;
      o_ovf_neg <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      pValid <= accept;
      if (accept) begin
        pFirst <= i_first;
        pLast <= i_last;
        pSf <= i_sf;
        pProd <= (2*MULW)'(i_a) * (2*MULW)'(i_b);
        pBias <= i_bias;
      end
      if (pValid) begin
        acc <= sum[ACCW-1:0];
        stickyPos <= flagPos;
        stickyNeg <= flagNeg;
      end
      o_valid <= pValid && pLast;
      if (pValid && pLast) begin
        o_mac <= macNext;
        o_ovf_pos <= flagPos;
        o_ovf_neg <= flagNeg;
      end
      // A new open sequence wins over the retirement of the previous last beat
      o_busy <= (accept && i_first && !i_last) ? 1'b1 : (pValid && pLast) ? 1'b0 : o_busy;
    end
  end
endmodule
